// File: rtl/rf_wb_pkg.sv
// Shared constants and FSM state type for the register-file
// write-back controller and its grant picker.
package rf_wb_pkg;

    localparam int NUM_REQ  = 3;
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int PTR_W    = 2;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } state_t;

endpackage

// File: rtl/rf_wb_pick.sv
// One-hot grant picker for the write-back requesters.
// Ports: req (request bits), ptr (last granted index, only when
// RF_WB_RR_EN is defined), gnt (one-hot grant, combinational).
// RF_WB_RR_EN defined: round-robin starting after ptr.
// RF_WB_RR_EN undefined: fixed priority 0 > 1 > 2.
module rf_wb_pick
    import rf_wb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
`ifdef RF_WB_RR_EN
    input  logic [PTR_W-1:0]   ptr,
`endif
    output logic [NUM_REQ-1:0] gnt
);

`ifdef RF_WB_RR_EN
    always_comb begin
        gnt = '0;
        case (ptr)
            2'd0: begin
                if (req[1])      gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
            end
            2'd1: begin
                if (req[2])      gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
            end
            default: begin
                if (req[0])      gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        endcase
    end
`else
    always_comb begin
        gnt = '0;
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
    end
`endif

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-back controller: arbitrates three write
// requesters onto one registered write port and runs a clear sweep.
// Ports: clk, rst (sync, active-high), req/waddrN/wdataN (requesters),
// gnt (one-hot, combinational), clr_req (start clear sweep),
// regen/inaddr/in (registered write port), busy, clr_done.
// Macro RF_WB_RR_EN selects round-robin instead of fixed priority.
module rf_wb_ctrl
    import rf_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [ADDR_W-1:0] waddr2,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    output logic [NUM_REQ-1:0] gnt,
    input  logic              clr_req,
    output logic              regen,
    output logic [ADDR_W-1:0] inaddr,
    output logic [DATA_W-1:0] in,
    output logic              busy,
    output logic              clr_done
);

    state_t              state;
    logic [NUM_REQ-1:0]  pick_gnt;
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_data;

`ifdef RF_WB_RR_EN
    logic [PTR_W-1:0] ptr;

    rf_wb_pick u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= PTR_W'(2);
        end else if (|gnt) begin
            unique case (1'b1)
                gnt[1]:  ptr <= PTR_W'(1);
                gnt[2]:  ptr <= PTR_W'(2);
                default: ptr <= PTR_W'(0);
            endcase
        end
    end
`else
    rf_wb_pick u_pick (
        .req (req),
        .gnt (pick_gnt)
    );
`endif

    // Clear has precedence over writes; nothing granted outside IDLE.
    assign gnt = (state == IDLE && !clr_req && !rst)
               ? pick_gnt : '0;

    always_comb begin
        g_addr = '0;
        g_data = '0;
        unique case (1'b1)
            gnt[0]: begin
                g_addr = waddr0;
                g_data = wdata0;
            end
            gnt[1]: begin
                g_addr = waddr1;
                g_data = wdata1;
            end
            gnt[2]: begin
                g_addr = waddr2;
                g_data = wdata2;
            end
            default: ;
        endcase
    end

    // During CLEAR, inaddr doubles as the sweep index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            regen    <= 1'b0;
            inaddr   <= '0;
            in       <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state  <= CLEAR;
                        regen  <= 1'b1;
                        inaddr <= '0;
                        in     <= '0;
                        busy   <= 1'b1;
                    end else begin
                        regen <= |gnt;
                        if (|gnt) begin
                            inaddr <= g_addr;
                            in     <= g_data;
                        end
                    end
                end
                CLEAR: begin
                    if (inaddr == ADDR_W'(NUM_REGS - 1)) begin
                        state    <= DONE;
                        regen    <= 1'b0;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        inaddr <= inaddr + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench for rf_wb_ctrl: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_rf_wb_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  wa [3];
    logic [15:0] wd [3];
    logic [2:0]  gnt;
    logic        clr_req;
    logic        regen;
    logic [2:0]  inaddr;
    logic [15:0] in;
    logic        busy;
    logic        clr_done;

    int checks   = 0;
    int failures = 0;

    rf_wb_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .waddr0   (wa[0]),
        .waddr1   (wa[1]),
        .waddr2   (wa[2]),
        .wdata0   (wd[0]),
        .wdata1   (wd[1]),
        .wdata2   (wd[2]),
        .gnt      (gnt),
        .clr_req  (clr_req),
        .regen    (regen),
        .inaddr   (inaddr),
        .in       (in),
        .busy     (busy),
        .clr_done (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file fed by the DUT write port.
    logic [15:0] rf_act [8];
    always @(posedge clk)
        if (regen === 1'b1) rf_act[inaddr] <= in;

    int done_cnt = 0;
    int wr_cnt   = 0;
    always @(negedge clk) begin
        if (clr_done === 1'b1) done_cnt++;
        if (regen === 1'b1 && busy === 1'b1) wr_cnt++;
    end

    // Behavioural model.
    int          m_sweep = -1;
    bit          m_done  = 0;
    int          m_last  = 2;
    int          m_gidx  = -1;
    logic        e_regen = 0;
    logic [2:0]  e_addr  = 0;
    logic [15:0] e_in    = 0;
    logic        e_busy  = 0;
    logic        e_cdone = 0;
    logic [15:0] rf_exp [8];

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic int pick(logic [2:0] r);
        for (int k = 0; k < 3; k++) begin
            int i;
`ifdef RF_WB_RR_EN
            i = (m_last + 1 + k) % 3;
`else
            i = k;
`endif
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic step();
        logic [2:0] eg;
        #1;
        if (rst || m_sweep >= 0 || m_done || clr_req)
            m_gidx = -1;
        else
            m_gidx = pick(req);
        eg = (m_gidx >= 0) ? 3'(1 << m_gidx) : 3'b000;
        chk("gnt", 32'(gnt), 32'(eg));
        @(posedge clk);
        if (e_regen) rf_exp[e_addr] = e_in;
        if (rst) begin
            m_sweep = -1; m_done = 0; m_last = 2;
            e_regen = 0; e_addr = 0; e_in = 0;
            e_busy = 0; e_cdone = 0;
        end else if (m_done) begin
            m_done = 0; e_cdone = 0; e_regen = 0;
        end else if (m_sweep >= 0) begin
            if (m_sweep < 7) begin
                m_sweep++;
                e_regen = 1; e_addr = 3'(m_sweep); e_in = 0;
            end else begin
                m_sweep = -1; m_done = 1;
                e_regen = 0; e_busy = 0; e_cdone = 1;
            end
        end else if (clr_req) begin
            m_sweep = 0;
            e_regen = 1; e_addr = 0; e_in = 0; e_busy = 1;
        end else if (m_gidx >= 0) begin
            e_regen = 1;
            e_addr  = wa[m_gidx];
            e_in    = wd[m_gidx];
            m_last  = m_gidx;
        end else begin
            e_regen = 0;
        end
        #1;
        chk("regen", 32'(regen), 32'(e_regen));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("clr_done", 32'(clr_done), 32'(e_cdone));
        if (e_regen || rst) begin
            chk("inaddr", 32'(inaddr), 32'(e_addr));
            chk("in", 32'(in), 32'(e_in));
        end
        @(negedge clk);
    endtask

    task automatic chk_rf(string tag);
        for (int r = 0; r < 8; r++)
            chk(tag, 32'(rf_act[r]), 32'(rf_exp[r]));
    endtask

    initial begin
        logic [2:0] seq [3];
        int d0;
        int w0;
        for (int r = 0; r < 8; r++) begin
            rf_exp[r] = 16'h0;
            rf_act[r] = 16'h0;
        end
        rst = 1; req = 0; clr_req = 0;
        for (int i = 0; i < 3; i++) begin
            wa[i] = 3'(i);
            wd[i] = 16'(i);
        end

        // Reset
        step();
        step();
        chk("rst_regen", 32'(regen), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_inaddr", 32'(inaddr), 0);
        rst = 0;

        // Three-way contention, pointer starting from reset.
`ifdef RF_WB_RR_EN
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100;
`else
        seq[0] = 3'b001; seq[1] = 3'b001; seq[2] = 3'b001;
`endif
        req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            wa[i] = 3'(i + 4);
            wd[i] = 16'($urandom);
        end
        for (int k = 0; k < 3; k++) begin
            #1 chk("contend_gnt", 32'(gnt), 32'(seq[k]));
            step();
        end
        req = 0;
        step();

        // Single write and its latency.
        req = 3'b001; wa[0] = 3'd3; wd[0] = 16'hBEEF;
        #1 chk("w_gnt", 32'(gnt), 32'b001);
        step();
        req = 0;
        chk("w_regen", 32'(regen), 1);
        chk("w_inaddr", 32'(inaddr), 3);
        chk("w_in", 32'(in), 32'hBEEF);
        step();
        chk("w_reg3", 32'(rf_act[3]), 32'hBEEF);

        // Idle requesters.
        for (int k = 0; k < 5; k++) begin
            #1 chk("idle_gnt", 32'(gnt), 0);
            step();
            chk("idle_regen", 32'(regen), 0);
        end

        // Clear with requester 1 pending.
        req = 3'b010; wa[1] = 3'd7; wd[1] = 16'h1234;
        clr_req = 1;
        d0 = done_cnt;
        #1 chk("clr_gnt", 32'(gnt), 0);
        step();
        clr_req = 0;
        for (int s = 1; s <= 9; s++) begin
            if (s <= 8) begin
                chk("clr_inaddr", 32'(inaddr), 32'(s - 1));
                chk("clr_in", 32'(in), 0);
            end else begin
                chk("clr_done_pulse", 32'(clr_done), 1);
                chk_rf("clr_rf");
            end
            #1 chk("clr_gnt", 32'(gnt), 0);
            step();
        end
        #1 chk("post_clr_gnt", 32'(gnt), 32'b010);
        step();
        req = 0;
        step();
        chk("clr_done_cnt", 32'(done_cnt - d0), 1);

        // Second clear request mid-sweep is ignored.
        d0 = done_cnt; w0 = wr_cnt;
        clr_req = 1;
        step();
        clr_req = 0;
        for (int s = 1; s <= 12; s++) begin
            clr_req = (s == 5);
            step();
        end
        clr_req = 0;
        chk("reclr_writes", 32'(wr_cnt - w0), 8);
        chk("reclr_done", 32'(done_cnt - d0), 1);

        // Reset aborts the sweep.
        d0 = done_cnt;
        clr_req = 1;
        step();
        clr_req = 0;
        for (int s = 1; s <= 6; s++) begin
            rst = (s == 6);
            step();
        end
        rst = 0;
        chk("abort_regen", 32'(regen), 0);
        chk("abort_busy", 32'(busy), 0);
        req = 3'b100; wa[2] = 3'd6; wd[2] = 16'hA5A5;
        #1 chk("abort_gnt", 32'(gnt), 32'b100);
        step();
        req = 0;
        for (int k = 0; k < 10; k++) step();
        chk("abort_no_done", 32'(done_cnt - d0), 0);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            clr_req = ($urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 149) == 0);
            step();
            if (m_gidx >= 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    req[m_gidx] = 1'b0;
                end else begin
                    wa[m_gidx] = 3'($urandom);
                    wd[m_gidx] = 16'($urandom);
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    wa[i] = 3'($urandom);
                    wd[i] = 16'($urandom);
                end
            end
        end
        rst = 0; clr_req = 0; req = 0;
        step();
        step();
        chk_rf("final_rf");

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_wb_ctrl.md
RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: rising-edge clock.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have the port req, input, 3 bits: per-requester write request; requester i holds its request until granted.
REQ-004 The block SHALL have the ports waddr0/waddr1/waddr2, input, 3 bits each: target register for each requester.
REQ-005 The block SHALL have the ports wdata0/wdata1/wdata2, input, 16 bits each: write data for each requester.
REQ-006 The block SHALL have the port gnt, output, 3 bits: one-hot, combinational; gnt[i]=1 means requester i is consumed at this edge.
REQ-007 The block SHALL have the port clr_req, input, 1 bit: one-cycle request to zero all 8 registers.
REQ-008 The block SHALL have the ports regen (output, 1 bit), inaddr (output, 3 bits) and in (output, 16 bits): registered register-file write port.
REQ-009 The block SHALL have the ports busy (output, 1 bit: clear sweep active) and clr_done (output, 1 bit: one-cycle pulse).

Function
REQ-010 The block SHALL implement three FSM states: IDLE, CLEAR and DONE.
REQ-011 In IDLE with clr_req=0, the block SHALL assert at most one gnt bit per cycle, and only for a requester whose req bit is set.
REQ-012 At the edge where gnt[i]=1, the block SHALL load regen=1, inaddr=waddri and in=wdatai; regen SHALL be 0 after any edge with no grant.
REQ-013 Latency SHALL be: req sampled at cycle N, regfile write port valid at cycle N+1, register updated at edge N+2.
REQ-014 A requester SHALL hold addr/data stable while req=1 and gnt=0, and SHALL drop or replace its request on the edge after gnt.
REQ-015 In IDLE with clr_req=1, clear SHALL win: gnt=0 in that cycle and the next state SHALL be CLEAR with the sweep index set to 0.
REQ-016 In CLEAR, the block SHALL issue regen=1, in=0 and inaddr=index for indexes 0..7 on 8 consecutive cycles, with busy=1 and gnt=0 throughout.
REQ-017 After index 7, CLEAR SHALL go to DONE; DONE SHALL drive clr_done=1 for exactly one cycle with gnt=0 and return to IDLE.
REQ-018 The block SHALL ignore clr_req while in CLEAR or DONE (no restart, no queueing).
REQ-019 Pending requests SHALL stay pending across a clear and SHALL be arbitrated normally from the first IDLE cycle.
REQ-020 Writes to address 7 (PC) SHALL be treated as ordinary writes, with no special priority.

Reset
REQ-021 While rst=1, the block SHALL hold state IDLE, regen=0, inaddr=0, in=0, busy=0, clr_done=0, gnt=0 and the round-robin pointer at 2.
REQ-022 An rst asserted mid-CLEAR SHALL abort the sweep with no clr_done pulse.

Configuration
REQ-023 When RF_WB_RR_EN is defined, arbitration SHALL be round-robin: the search starts at (last granted+1) mod 3, and the pointer updates only on a grant.
REQ-024 When RF_WB_RR_EN is undefined, arbitration SHALL be fixed priority 0>1>2, and the pointer logic SHALL be absent.

Structure
REQ-025 Package rf_wb_pkg SHALL hold NUM_REQ=3, ADDR_W=3, DATA_W=16, NUM_REGS=8 and the FSM state enum (IDLE, CLEAR, DONE).
REQ-026 Sub-module rf_wb_pick SHALL implement the combinational one-hot picker (req plus pointer to gnt), and SHALL be selectable between round-robin and fixed priority by the macro.

Verification
REQ-027 The bench SHALL check: req=001, waddr0=3, wdata0=16'hBEEF -> gnt=001 the same cycle; next cycle regen=1, inaddr=3, in=BEEF; register 3 = BEEF one edge later.
REQ-028 The bench SHALL check: req=111 held for 3 grants with RF_WB_RR_EN -> gnt order 001, 010, 100; without the macro -> 001 for as long as req[0] is held.
REQ-029 The bench SHALL check: clr_req pulse with req=010 pending -> gnt=0 for 10 cycles; inaddr 0..7 with in=0; clr_done for 1 cycle; gnt=010 on the first IDLE cycle.
REQ-030 The bench SHALL check: second clr_req at sweep index 4 -> ignored; exactly 8 clear writes and one clr_done.
REQ-031 The bench SHALL check: rst at sweep index 5 -> next cycle regen=0, busy=0, no clr_done; the next req=100 is granted first.
REQ-032 The bench SHALL check: req=000 for 5 cycles -> regen=0 and gnt=000 throughout.
